// File: rtl/graphics_op_scheduler.sv
// Command queue and dispatcher: host pushes drawing commands, the FSM programs one
// engine's CSRs, pulses its start, then routes its pixel stream to the frame-buffer writer.
module graphics_op_scheduler #(
  parameter int NUM_ENGINES       = 2,
  parameter int FIFO_DEPTH        = 8,
  parameter int MM_CSR_DATA_WIDTH = 32,
  parameter int MM_CSR_ADDR_WIDTH = 4,
  parameter int ST_DATA_WIDTH     = 32
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic                                   clken,
  input  logic                                   host_write,
  input  logic                                   host_read,
  input  logic [2:0]                             host_address,
  input  logic [MM_CSR_DATA_WIDTH-1:0]           host_writedata,
  output logic [MM_CSR_DATA_WIDTH-1:0]           host_readdata,
  output logic                                   host_waitrequest,
  output logic [NUM_ENGINES-1:0]                 eng_csr_write,
  output logic [MM_CSR_ADDR_WIDTH-1:0]           eng_csr_address,
  output logic [MM_CSR_DATA_WIDTH-1:0]           eng_csr_writedata,
  input  logic [NUM_ENGINES-1:0]                 eng_csr_waitrequest,
  output logic [NUM_ENGINES-1:0]                 eng_start,
  input  logic [NUM_ENGINES-1:0]                 eng_done,
  input  logic [NUM_ENGINES*ST_DATA_WIDTH-1:0]   eng_st_data,
  input  logic [NUM_ENGINES-1:0]                 eng_st_valid,
  output logic [NUM_ENGINES-1:0]                 eng_st_ready,
  output logic [ST_DATA_WIDTH-1:0]               out_st_data,
  output logic                                   out_st_valid,
  input  logic                                   out_st_ready,
  output logic                                   busy
);

  localparam int ENG_W = (NUM_ENGINES > 1) ? $clog2(NUM_ENGINES) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  // The whole low byte is kept as the id so out-of-range engine numbers are caught, not aliased.
  localparam int ID_W  = 8;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_START, S_RUN} state_t;

  typedef struct packed {
    logic [ID_W-1:0]                   id;
    logic [2:0][MM_CSR_DATA_WIDTH-1:0] par;
  } cmd_t;

  state_t r_state, w_nextState;
  cmd_t   r_fifo [FIFO_DEPTH];
  logic [PTR_W-1:0]                  r_wrPtr, r_rdPtr;
  logic [CNT_W-1:0]                  r_count;
  logic [2:0][MM_CSR_DATA_WIDTH-1:0] r_param, r_cur;
  logic [ID_W-1:0]                   r_id;
  logic [1:0]                        r_k;
  logic                              r_err;

  logic             w_empty, w_full, w_push, w_pop, w_headOk, w_csrAccept;
  logic [ENG_W-1:0] w_eng;
  cmd_t             w_head;

  assign w_empty     = (r_count == '0);
  assign w_full      = (r_count == CNT_W'(FIFO_DEPTH));
  assign w_push      = host_write & (host_address == 3'd3) & ~w_full;
  assign w_head      = r_fifo[r_rdPtr];
  assign w_headOk    = (w_head.id < ID_W'(NUM_ENGINES));
  assign w_pop       = (r_state == S_IDLE) & clken & ~w_empty;
  assign w_eng       = r_id[ENG_W-1:0];
  assign w_csrAccept = (r_state == S_LOAD) & clken & ~eng_csr_waitrequest[w_eng];

  assign host_waitrequest = host_write & (host_address == 3'd3) & w_full;
  assign busy             = ~w_empty | (r_state != S_IDLE);

  always_ff @(posedge clk) begin
    if (w_push) r_fifo[r_wrPtr] <= '{id: host_writedata[ID_W-1:0], par: r_param};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
      r_param <= '0;
      r_cur   <= '0;
      r_id    <= '0;
      r_k     <= '0;
      r_err   <= 1'b0;
    end else begin
      if (host_write && host_address < 3'd3) r_param[host_address[1:0]] <= host_writedata;
      if (w_push) r_wrPtr <= r_wrPtr + 1'b1;
      if (w_pop)  r_rdPtr <= r_rdPtr + 1'b1;
      r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
      if (w_pop && !w_headOk)                        r_err <= 1'b1;
      else if (host_write && host_address == 3'd4)   r_err <= 1'b0;
      if (w_pop && w_headOk) begin
        r_id  <= w_head.id;
        r_cur <= w_head.par;
        r_k   <= '0;
      end else if (w_csrAccept) begin
        r_k <= r_k + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      S_IDLE:  if (w_pop && w_headOk) w_nextState = S_LOAD;
      S_LOAD:  if (w_csrAccept && r_k == 2'd2) w_nextState = S_START;
      S_START: if (clken) w_nextState = S_RUN;
      S_RUN:   if (clken && eng_done[w_eng]) w_nextState = S_IDLE;
      default: w_nextState = S_IDLE;
    endcase
  end

  // Strobes are qualified by clken so an engine never sees a write or start the FSM does not count.
  always_comb begin
    eng_csr_write     = '0;
    eng_csr_address   = '0;
    eng_csr_writedata = '0;
    eng_start         = '0;
    eng_st_ready      = '0;
    out_st_data       = '0;
    out_st_valid      = 1'b0;
    case (r_state)
      S_LOAD: begin
        eng_csr_write[w_eng] = clken;
        eng_csr_address      = MM_CSR_ADDR_WIDTH'(r_k);
        case (r_k)
          2'd0:    eng_csr_writedata = r_cur[0];
          2'd1:    eng_csr_writedata = r_cur[1];
          default: eng_csr_writedata = r_cur[2];
        endcase
      end
      S_START: eng_start[w_eng] = clken;
      S_RUN: begin
        out_st_data         = eng_st_data[int'(w_eng)*ST_DATA_WIDTH +: ST_DATA_WIDTH];
        out_st_valid        = eng_st_valid[w_eng] & clken;
        eng_st_ready[w_eng] = out_st_ready;
      end
      default: ;
    endcase
  end

  always_comb begin
    host_readdata = '0;
    if (host_read) begin
      case (host_address)
        3'd0, 3'd1, 3'd2: host_readdata = r_param[host_address[1:0]];
        3'd4:             host_readdata[CNT_W+2:0] = {r_count, r_err, w_full, busy};
        default:          host_readdata = '0;
      endcase
    end
  end

endmodule
